// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants, field positions and fetch FSM encoding.
package riscv_pkg;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int OPC_LSB = 0;
    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_LSB  = 25;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} fetch_state_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// imem_if: single-outstanding instruction memory req/ready + rvalid bus.
interface imem_if #(parameter int XLEN = 32);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    modport master (output imem_req, imem_addr, input imem_ready, imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ready, imem_rvalid, imem_rdata);
endinterface

// File: rtl/instr_fetch_unit_if_id_slot.sv
// if_id_slot: output register holding the fetched instruction, its pc and valid.
module if_id_slot import riscv_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_clear,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_valid,
    output logic [31:0]     o_instr,
    output logic [XLEN-1:0] o_pc
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_instr <= NOP_INSTR;
            o_pc    <= '0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_instr <= i_instr;
            o_pc    <= i_pc;
        end else if (i_clear) begin
            o_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches one instruction at a time and
// presents it with decoded fields to the control unit.
module instr_fetch_unit import riscv_pkg::*; #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    imem_if.master          imem,
    input  logic            i_stall,
    input  logic            i_pc_src,
    input  logic [XLEN-1:0] i_pc_target,
    output logic            o_instr_valid,
    output logic [31:0]     o_instr,
    output logic [XLEN-1:0] o_instr_pc,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic [6:0]      o_opcode,
    output logic [2:0]      o_funct3,
    output logic [6:0]      o_funct7,
    output logic [4:0]      o_rd,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2
);
    fetch_state_t    r_state, w_next;
    logic [XLEN-1:0] r_fetch_pc;
    logic            w_consume, w_redirect, w_slot_free, w_req, w_resp;

    assign w_consume   = o_instr_valid & ~i_stall;
    assign w_redirect  = w_consume & i_pc_src;
    assign w_slot_free = ~o_instr_valid | w_consume;

    always_comb begin
        w_req  = 1'b0;
        w_resp = 1'b0;
        w_next = r_state;
        w_req  = (r_state == REQ) & w_slot_free & ~w_redirect;
        w_resp = (r_state == WAIT) & imem.imem_rvalid;
        w_next = (r_state == IDLE) ? REQ :
                 (r_state == REQ)  ? ((w_req & imem.imem_ready) ? WAIT : REQ) :
                 (w_resp ? REQ : WAIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state <= w_next;
            if (w_redirect)
                r_fetch_pc <= i_pc_target;
            else if (w_resp)
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
        end
    end

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_fetch_pc;

    if_id_slot #(.XLEN(XLEN)) u_slot (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_resp),
        .i_clear (w_consume),
        .i_instr (imem.imem_rdata[31:0]),
        .i_pc    (r_fetch_pc),
        .o_valid (o_instr_valid),
        .o_instr (o_instr),
        .o_pc    (o_instr_pc)
    );

    assign o_pc_plus4 = o_instr_pc + XLEN'(4);
    assign o_opcode   = o_instr[OPC_LSB +: 7];
    assign o_rd       = o_instr[RD_LSB  +: 5];
    assign o_funct3   = o_instr[F3_LSB  +: 3];
    assign o_rs1      = o_instr[RS1_LSB +: 5];
    assign o_rs2      = o_instr[RS2_LSB +: 5];
    assign o_funct7   = o_instr[F7_LSB  +: 7];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch timing, stall, backpressure,
// redirect, wrap and async reset against a one-cycle-latency memory.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] pc_target = '0;
    logic        ready = 1'b1;
    logic        stray = 1'b0;
    logic        pend;
    logic [31:0] paddr;
    logic        instr_valid;
    logic [31:0] instr, instr_pc, pc_plus4;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    imem_if #(.XLEN(32)) bus ();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : a + 32'h13;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend  <= 1'b0;
            paddr <= '0;
        end else begin
            pend  <= bus.imem_req & bus.imem_ready;
            paddr <= bus.imem_addr;
        end
    end

    assign bus.imem_ready  = ready;
    assign bus.imem_rvalid = pend | stray;
    assign bus.imem_rdata  = mem_word(paddr);

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem          (bus),
        .i_stall       (stall),
        .i_pc_src      (pc_src),
        .i_pc_target   (pc_target),
        .o_instr_valid (instr_valid),
        .o_instr       (instr),
        .o_instr_pc    (instr_pc),
        .o_pc_plus4    (pc_plus4),
        .o_opcode      (opcode),
        .o_funct3      (funct3),
        .o_funct7      (funct7),
        .o_rd          (rd),
        .o_rs1         (rs1),
        .o_rs2         (rs2)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, act, exp);
        end
    endtask

    initial begin
        @(negedge clk);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h13);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_req", 32'(bus.imem_req), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_valid", 32'(instr_valid), 32'd0);
        check("req0", 32'(bus.imem_req), 32'd1);
        check("addr0", bus.imem_addr, 32'h0);
        @(negedge clk);
        check("wait_req", 32'(bus.imem_req), 32'd0);
        check("wait_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("lat3_valid", 32'(instr_valid), 32'd1);
        check("instr0", instr, 32'h0050_0093);
        check("opcode0", 32'(opcode), 32'h13);
        check("rd0", 32'(rd), 32'd1);
        check("funct3_0", 32'(funct3), 32'd0);
        check("rs1_0", 32'(rs1), 32'd0);
        check("rs2_0", 32'(rs2), 32'd5);
        check("funct7_0", 32'(funct7), 32'd0);
        check("plus4_0", pc_plus4, 32'h4);
        check("req1", 32'(bus.imem_req), 32'd1);
        check("addr1", bus.imem_addr, 32'h4);
        stall = 1'b1;
        #1 check("stall_req", 32'(bus.imem_req), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_hold_req", 32'(bus.imem_req), 32'd0);
            check("stall_hold_instr", instr, 32'h0050_0093);
            check("stall_hold_valid", 32'(instr_valid), 32'd1);
        end
        stall = 1'b0;
        #1 check("unstall_req", 32'(bus.imem_req), 32'd1);
        check("unstall_addr", bus.imem_addr, 32'h4);
        @(negedge clk);
        check("consumed_valid", 32'(instr_valid), 32'd0);
        check("consumed_instr", instr, 32'h0050_0093);
        @(negedge clk);
        check("i4_pc", instr_pc, 32'h4);
        check("i4_instr", instr, 32'h17);
        check("req8", 32'(bus.imem_req), 32'd1);
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_req", 32'(bus.imem_req), 32'd1);
            check("bp_addr", bus.imem_addr, 32'h8);
        end
        check("bp_valid", 32'(instr_valid), 32'd0);
        ready = 1'b1;
        @(negedge clk);
        check("bp_wait_req", 32'(bus.imem_req), 32'd0);
        @(negedge clk);
        check("i8_pc", instr_pc, 32'h8);
        check("i8_instr", instr, 32'h1B);
        pc_src = 1'b1;
        pc_target = 32'h40;
        #1 check("redir_req", 32'(bus.imem_req), 32'd0);
        @(negedge clk);
        pc_src = 1'b0;
        check("redir_valid", 32'(instr_valid), 32'd0);
        check("redir_req_next", 32'(bus.imem_req), 32'd1);
        check("redir_addr", bus.imem_addr, 32'h40);
        @(negedge clk);
        @(negedge clk);
        check("i40_pc", instr_pc, 32'h40);
        check("i40_instr", instr, 32'h53);
        pc_src = 1'b1;
        pc_target = 32'hFFFF_FFFC;
        @(negedge clk);
        pc_src = 1'b0;
        check("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        @(negedge clk);
        check("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        check("wrap_plus4", pc_plus4, 32'h0);
        check("wrap_instr", instr, 32'h0000_000F);
        check("wrap_next_addr", bus.imem_addr, 32'h0);
        @(negedge clk);
        check("pre_rst_wait", 32'(bus.imem_req), 32'd0);
        rst = 1'b1;
        #1 check("arst_valid", 32'(instr_valid), 32'd0);
        check("arst_instr", instr, 32'h13);
        check("arst_pc", instr_pc, 32'h0);
        check("arst_req", 32'(bus.imem_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        stray = 1'b1;
        @(negedge clk);
        check("stray_valid", 32'(instr_valid), 32'd0);
        check("post_rst_req", 32'(bus.imem_req), 32'd1);
        check("post_rst_addr", bus.imem_addr, 32'h0);
        @(negedge clk);
        stray = 1'b0;
        check("stray_req_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("post_rst_valid", 32'(instr_valid), 32'd1);
        check("post_rst_pc", instr_pc, 32'h0);
        check("post_rst_instr", instr, 32'h0050_0093);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of main_control_unit.
- Owns the PC and issues single-outstanding requests to instruction memory over a req/ready + rvalid handshake.
- Holds the fetched instruction in an output slot and slices opcode/funct3/funct7 (plus register indices) for the control unit and register file.
- Consumes pc_src and the branch/jump target produced downstream to redirect fetch.

Parameters:
- XLEN, 32, address and instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address; stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  read data valid; at most one per accepted request; no backpressure.
- imem_rdata  in  XLEN  instruction word.
- stall  in  1  downstream not accepting the presented instruction.
- pc_src  in  1  redirect request, meaningful only with instr_valid.
- pc_target  in  XLEN  redirect address.
- instr_valid  out  1  output slot holds a live instruction.
- instr  out  32  slot instruction.
- instr_pc  out  XLEN  address of slot instruction.
- pc_plus4  out  XLEN  instr_pc+4, for jal/jalr link.
- opcode  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- funct7  out  7  instr[31:25].
- rd, rs1, rs2  out  5 each  instr[11:7], [19:15], [24:20].

Behaviour:
- Reset (async, any state, including mid-request) forces:
  - fetch_pc=RESET_PC, state=IDLE, instr_valid=0.
  - instr=32'h0000_0013 (NOP), instr_pc=0, imem_req=0.
- Any rvalid pending at reset is ignored afterwards; the memory must be reset together with this block.
- Field outputs are pure slices of the instr register; pc_plus4 = instr_pc+4, wrapping modulo 2^XLEN.
- consume = instr_valid & ~stall. redirect = consume & pc_src. slot_free = ~instr_valid | consume.
- FSM states:
  - IDLE: one cycle after reset release, no request; then go to REQ.
  - REQ: imem_req = slot_free & ~redirect; imem_addr = fetch_pc. On imem_req & imem_ready, go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid: instr<=imem_rdata, instr_pc<=fetch_pc, instr_valid<=1, fetch_pc<=fetch_pc+4 (wraps), go to REQ.
- Slot rules:
  - On consume with no load in the same cycle, instr_valid<=0; instr and instr_pc keep their values.
  - Because a request is issued only when the slot is free, a response never finds the slot occupied. No data is ever dropped.
- Redirect:
  - Can only occur in REQ, since the slot is empty throughout WAIT.
  - fetch_pc<=pc_target, instr_valid<=0, and the request is suppressed that cycle.
  - The next cycle requests pc_target.
- Once asserted, imem_req and imem_addr are held until imem_ready. The slot is empty while the request is pending, so no redirect can intervene.
- imem_rvalid in IDLE or REQ is a protocol error: ignored, no state change.
- Throughput: with ready=1 and rvalid one cycle after acceptance, one instruction every 2 cycles. Latency from reset release to first instr_valid is 3 cycles.
- pc_target is used as given. Misalignment is handled downstream.

Decomposition:
- Shared package riscv_pkg holds:
  - NOP_INSTR=32'h0000_0013.
  - Field bit positions.
  - FSM state encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2).
  - RESET_PC default.
- One natural sub-module: if_id_slot, the output register holding instr, instr_pc and instr_valid, with its load/consume/clear logic.
- FSM and PC stay in the top module.

Test Plan:
- Reset release, ready=1, rvalid 1 cycle after accept, rdata=0x00500093 → req at addr 0x0. First instr_valid exactly 3 cycles after release, opcode=0x13, rd=1, pc_plus4=0x4. Second req at 0x4.
- stall=1 for 5 cycles with slot valid → imem_req stays 0 and instr is stable. On stall drop, req issues for the next pc in the same cycle.
- imem_ready low for 4 cycles → imem_req and imem_addr held constant, no state change; proceeds when ready rises.
- Slot holds instr_pc=0x8, pc_src=1, pc_target=0x40 → no request that cycle, instr_valid drops. Next cycle req at 0x40; following instruction has instr_pc=0x40.
- Assert rst while in WAIT → outputs return to reset values immediately (async). A stray rvalid after release is ignored; first fetch is at RESET_PC.
- pc_target=0xFFFF_FFFC, then sequential fetch → instr_pc=0xFFFF_FFFC, pc_plus4=0x0, next req addr 0x0.
